bcd_key_encoder: RTL and testbench
==================================

Name: bcd_key_encoder

Overview:
- Sequential 10:4 encoder: the inverse of the team's 4:10 one-hot decoder.
- Takes ten raw active-high key/select lines, debounces them, and priority-encodes the pressed line to a 4-bit code 0..9.
- Presents the code on a valid/ready handshake, one event per press.
- Sits between raw keypad/select inputs and BCD consumers; the code can be fed back through the decoder.

Parameters:
- DEBOUNCE, 4, consecutive stable samples required to accept a press or a release; must be >= 1.
- CNT_W, 8, width of the accepted-press counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key  input  10  raw key lines, active-high. Bit n means digit n. Asynchronous to clk; the bench drives it synchronously.
- out_ready  input  1  consumer can accept out_code.
- out_valid  output  1  out_code/out_multi hold a debounced press.
- out_code  output  4  encoded digit, 0..9.
- out_multi  output  1  more than one key was set in the accepted pattern.
- press_cnt  output  CNT_W  count of handshaked presses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous assert, any state, including mid-debounce or mid-handshake):
  - state = IDLE; out_valid, out_code, out_multi, press_cnt, internal sample register and debounce counter all = 0.
  - Leaves reset on the first rising edge after rst_n goes high.
- Encoding:
  - Highest-index set bit wins: bits 3 and 8 set gives code 8.
  - out_multi = 1 iff popcount(pattern) >= 2.
  - Codes 10..15 are never produced.
- State machine (IDLE, DEBOUNCE, PRESENT, RELEASE):
  - IDLE:
    - key == 0: stay.
    - key != 0: store key in samp, clear cnt, go to DEBOUNCE. This is the capture edge.
  - DEBOUNCE:
    - key == samp: cnt++.
    - On the DEBOUNCE-th consecutive matching edge after capture: register code/multi from samp, set out_valid = 1, go to PRESENT.
    - key != samp and key != 0: recapture samp = key, cnt = 0, stay.
    - key == 0: go to IDLE, cnt = 0.
    - Latency with DEBOUNCE=4 and a clean press: out_valid rises on the 4th edge after the capture edge.
  - PRESENT:
    - out_valid = 1; out_code and out_multi held stable; key is ignored.
    - Edge with out_valid && out_ready: out_valid = 0, press_cnt++, go to RELEASE, cnt = 0.
    - out_valid never drops without a handshake except on reset.
  - RELEASE:
    - key == 0: cnt++; after DEBOUNCE consecutive zero samples, go to IDLE.
    - Any nonzero sample clears cnt; stay in RELEASE.
    - A second key pressed while the first is held, or before release completes, is never reported.
- out_code and out_multi keep their last value after the handshake; they are don't-care while out_valid = 0, but must not be X.
- press_cnt wraps: from 2^CNT_W-1 back to 0.
- No combinational path from key or out_ready to any output. All outputs are registered.

Test Plan:
1. Reset: rst_n=0 with key=10'h3FF and out_ready=1 for 3 cycles -> out_valid=0, out_code=0, out_multi=0, press_cnt=0 throughout; after release of reset with key=0 -> stays IDLE, no output.
2. Clean press: DEBOUNCE=4, key=10'h020 (digit 5), out_ready=1 -> out_valid=1 on the 4th edge after capture, out_code=5, out_multi=0. Valid lasts exactly 1 cycle; press_cnt=1. Then key=0 for 4 cycles, then key=10'h200 -> second event with out_code=9, press_cnt=2.
3. Bounce: key alternates 10'h020 / 0 every cycle for 6 cycles, then steady 10'h020 -> no out_valid during bouncing; exactly one event, code 5, 4 edges after the last capture.
4. Multi-key: key=10'h108 (bits 3 and 8) steady -> out_code=8, out_multi=1. Then key=10'h001 -> out_code=0, out_multi=0, but only after a full release.
5. Backpressure: out_ready=0, key=10'h020 accepted. While held, key changes to 10'h200, then 0, then 10'h200 -> out_valid and out_code=5 stay stable. After out_ready=1 for one edge: out_valid=0 and no event for 9 while 10'h200 remains held.
6. Reset mid-operation and wrap: CNT_W=2 build, 5 clean presses -> press_cnt sequence 1,2,3,0,1. Then assert rst_n=0 during DEBOUNCE -> immediate return to IDLE, press_cnt=0, out_valid=0 with no clock edge required.

Source files
------------

// File: rtl/bcd_key_if.sv
// Handshake bundle between a 10-line key encoder and its BCD consumer.
//   key       : raw active-high key lines, bit n means digit n
//   out_ready : consumer can take the presented code
//   out_valid : out_code/out_multi hold a debounced press
//   out_code  : encoded digit 0..9
//   out_multi : more than one line was set in the accepted pattern
//   press_cnt : number of handshaked presses, wraps modulo 2^CNT_W
// master = key source / code consumer side, slave = encoder side.
interface bcd_key_if #(
  parameter int CNT_W = 8
);
  logic [9:0]       key;
  logic             out_ready;
  logic             out_valid;
  logic [3:0]       out_code;
  logic             out_multi;
  logic [CNT_W-1:0] press_cnt;

  modport master (
    output key, out_ready,
    input  out_valid, out_code, out_multi, press_cnt
  );

  modport slave (
    input  key, out_ready,
    output out_valid, out_code, out_multi, press_cnt
  );
endinterface

// File: rtl/bcd_key_encoder.sv
// Debounced 10:4 priority key encoder with a valid/ready output.
// A nonzero key pattern must be seen unchanged on DEBOUNCE consecutive edges
// after its capture edge before it is presented. The highest set line wins;
// out_multi flags patterns with two or more lines set. Once presented, the
// code is held until handshaked, after which all lines must read zero for
// DEBOUNCE consecutive edges before a new press can be captured.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : bcd_key_if slave (key, out_ready in; out_valid, out_code,
//           out_multi, press_cnt out; all outputs registered)
module bcd_key_encoder #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  bcd_key_if.slave   bus
);

  // cnt only ever counts 0..DEBOUNCE-1
  localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESENT,
    ST_RELEASE
  } state_t;

  state_t           state_reg, state_next;
  logic [9:0]       samp_reg, samp_next;
  logic [DB_W-1:0]  cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [3:0]       out_code_reg, out_code_next;
  logic             out_multi_reg, out_multi_next;
  logic [CNT_W-1:0] press_cnt_reg, press_cnt_next;

  logic             key_nz;
  logic             key_match;
  logic             cnt_last;
  logic [3:0]       enc_code;
  logic             enc_multi;

  assign key_nz    = |bus.key;
  assign key_match = (bus.key == samp_reg);
  assign cnt_last  = (cnt_reg == DB_W'(DEBOUNCE - 1));

  // Priority encode the captured sample: later (higher) bits overwrite.
  always_comb begin
    enc_code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (samp_reg[i]) enc_code = 4'(i);
    end
    enc_multi = ($countones(samp_reg) >= 2);
  end

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      samp_reg      <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_code_reg  <= 4'd0;
      out_multi_reg <= 1'b0;
      press_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      samp_reg      <= samp_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_code_reg  <= out_code_next;
      out_multi_reg <= out_multi_next;
      press_cnt_reg <= press_cnt_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (key_nz) state_next = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!key_nz)                    state_next = ST_IDLE;
        else if (key_match && cnt_last) state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_valid_reg && bus.out_ready) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!key_nz && cnt_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    samp_next      = samp_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_code_next  = out_code_reg;
    out_multi_next = out_multi_reg;
    press_cnt_next = press_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (key_nz) begin
          samp_next = bus.key;
          cnt_next  = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!key_nz) begin
          cnt_next = '0;
        end else if (key_match) begin
          if (cnt_last) begin
            out_code_next  = enc_code;
            out_multi_next = enc_multi;
            out_valid_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + DB_W'(1);
          end
        end else begin
          // pattern changed mid-debounce: restart on the new pattern
          samp_next = bus.key;
          cnt_next  = '0;
        end
      end
      ST_PRESENT: begin
        if (out_valid_reg && bus.out_ready) begin
          out_valid_next = 1'b0;
          press_cnt_next = press_cnt_reg + CNT_W'(1);
          cnt_next       = '0;
        end
      end
      ST_RELEASE: begin
        // any nonzero sample restarts the quiet-period count
        if (key_nz || cnt_last) cnt_next = '0;
        else                    cnt_next = cnt_reg + DB_W'(1);
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_code  = out_code_reg;
  assign bus.out_multi = out_multi_reg;
  assign bus.press_cnt = press_cnt_reg;

endmodule

// File: tb/tb_bcd_key_encoder.sv
// Self-checking bench for bcd_key_encoder (DEBOUNCE=4, CNT_W=2 so the press
// counter wraps within a short run). Directed scenarios followed by random
// press episodes checked against an event-level model of the key protocol.
module tb_bcd_key_encoder;

  localparam int DB = 4;
  localparam int CW = 2;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [CW-1:0] exp_cnt = '0;

  bcd_key_if #(.CNT_W(CW)) bus ();

  bcd_key_encoder #(.DEBOUNCE(DB), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: highest set line index and multi flag from plain arithmetic.
  function automatic logic [3:0] ref_code(input logic [9:0] p);
    return 4'($clog2(int'(p) + 1) - 1);
  endfunction

  function automatic logic ref_multi(input logic [9:0] p);
    return (p & (p - 10'd1)) != 10'd0;
  endfunction

  // Apply inputs, take one rising edge, settle just after it.
  task automatic step(input logic [9:0] k, input logic r);
    bus.key = k;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key = 10'h3FF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.out_valid, bus.out_code, bus.out_multi, bus.press_cnt} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got v=%b c=%0d m=%b n=%0d exp all 0",
                 i, bus.out_valid, bus.out_code, bus.out_multi, bus.press_cnt);
      end
    end
    bus.key = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(10'h000, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.press_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got v=%b n=%0d exp v=0 n=0",
                 i, bus.out_valid, bus.press_cnt);
      end
    end
    exp_cnt = '0;
    $display("reset: done");
  endtask

  task automatic test_clean_press();
    logic [9:0] pats [2];
    pats[0] = 10'h020;
    pats[1] = 10'h200;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c <= DB; c++) begin
        step(pats[p], 1'b1);
        n_checks++;
        if (bus.out_valid !== (c == DB)) begin
          n_fail++;
          $display("FAIL clean_valid pat=%h edge=%0d got=%b exp=%b", pats[p], c, bus.out_valid, c == DB);
        end
      end
      n_checks++;
      if (bus.out_code !== ref_code(pats[p]) || bus.out_multi !== 1'b0) begin
        n_fail++;
        $display("FAIL clean_code pat=%h got c=%0d m=%b exp c=%0d m=0", pats[p], bus.out_code, bus.out_multi, ref_code(pats[p]));
      end
      step(pats[p], 1'b1);
      exp_cnt++;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.press_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL clean_handshake pat=%h got v=%b n=%0d exp v=0 n=%0d", pats[p], bus.out_valid, bus.press_cnt, exp_cnt);
      end
      for (int z = 0; z < DB; z++) step(10'h000, 1'b1);
      $display("clean press: key=%h code=%0d cnt=%0d", pats[p], bus.out_code, bus.press_cnt);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 10'h020 : 10'h000, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_quiet cyc=%0d got v=%b exp v=0", i, bus.out_valid);
      end
    end
    for (int c = 0; c <= DB; c++) begin
      step(10'h020, 1'b1);
      n_checks++;
      if (bus.out_valid !== (c == DB)) begin
        n_fail++;
        $display("FAIL bounce_valid edge=%0d got=%b exp=%b", c, bus.out_valid, c == DB);
      end
    end
    n_checks++;
    if (bus.out_code !== 4'd5) begin
      n_fail++;
      $display("FAIL bounce_code got=%0d exp=5", bus.out_code);
    end
    step(10'h020, 1'b1);
    exp_cnt++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.press_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL bounce_handshake got v=%b n=%0d exp v=0 n=%0d", bus.out_valid, bus.press_cnt, exp_cnt);
    end
    for (int z = 0; z < DB; z++) step(10'h000, 1'b1);
    $display("bounce press: code=%0d cnt=%0d", bus.out_code, bus.press_cnt);
  endtask

  task automatic test_multi_key();
    logic [9:0] pats [2];
    pats[0] = 10'h108;
    pats[1] = 10'h001;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c <= DB; c++) begin
        step(pats[p], 1'b1);
        n_checks++;
        if (bus.out_valid !== (c == DB)) begin
          n_fail++;
          $display("FAIL multi_valid pat=%h edge=%0d got=%b exp=%b", pats[p], c, bus.out_valid, c == DB);
        end
      end
      n_checks++;
      if (bus.out_code !== ref_code(pats[p]) || bus.out_multi !== ref_multi(pats[p])) begin
        n_fail++;
        $display("FAIL multi_code pat=%h got c=%0d m=%b exp c=%0d m=%b", pats[p],
                 bus.out_code, bus.out_multi, ref_code(pats[p]), ref_multi(pats[p]));
      end
      step(pats[p], 1'b1);
      exp_cnt++;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.press_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL multi_handshake got v=%b n=%0d exp v=0 n=%0d", bus.out_valid, bus.press_cnt, exp_cnt);
      end
      $display("multi press: key=%h code=%0d multi=%b cnt=%0d", pats[p], bus.out_code, bus.out_multi, bus.press_cnt);
      if (p == 0) begin
        // next key arrives without a release: must not be reported
        for (int i = 0; i < 6; i++) begin
          step(10'h001, 1'b1);
          n_checks++;
          if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_no_release cyc=%0d got v=%b exp v=0", i, bus.out_valid);
          end
        end
      end
      for (int z = 0; z < DB; z++) step(10'h000, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] held [6];
    held[0] = 10'h200; held[1] = 10'h200; held[2] = 10'h000;
    held[3] = 10'h000; held[4] = 10'h200; held[5] = 10'h200;
    for (int c = 0; c <= DB; c++) step(10'h020, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(held[i], 1'b0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd5 || bus.press_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v=%b c=%0d n=%0d exp v=1 c=5 n=%0d",
                 i, bus.out_valid, bus.out_code, bus.press_cnt, exp_cnt);
      end
    end
    step(10'h200, 1'b1);
    exp_cnt++;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.press_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL bp_handshake got v=%b n=%0d exp v=0 n=%0d", bus.out_valid, bus.press_cnt, exp_cnt);
    end
    $display("backpressure press: code=5 cnt=%0d", bus.press_cnt);
    for (int i = 0; i < 10; i++) begin
      step(10'h200, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_no_second cyc=%0d got v=%b exp v=0", i, bus.out_valid);
      end
    end
    for (int z = 0; z < DB; z++) step(10'h000, 1'b1);
  endtask

  task automatic test_wrap_and_async_reset();
    logic [CW-1:0] seq [5];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
    // asynchronous reset between edges
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.press_cnt !== '0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_idle got v=%b n=%0d exp v=0 n=0", bus.out_valid, bus.press_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = '0;
    step(10'h000, 1'b1);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c <= DB; c++) step(10'h004, 1'b1);
      step(10'h004, 1'b1);
      n_checks++;
      if (bus.press_cnt !== seq[p]) begin
        n_fail++;
        $display("FAIL wrap_cnt press=%0d got=%0d exp=%0d", p, bus.press_cnt, seq[p]);
      end
      $display("wrap press %0d: cnt=%0d", p, bus.press_cnt);
      for (int z = 0; z < DB; z++) step(10'h000, 1'b1);
    end
    // reset while a code is being presented
    for (int c = 0; c <= DB; c++) step(10'h040, 1'b0);
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.press_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset_present got v=%b n=%0d exp v=0 n=0", bus.out_valid, bus.press_cnt);
    end
    rst_n = 1'b1;
    step(10'h000, 1'b0);
    // reset mid-debounce: the following press must take a full debounce
    step(10'h040, 1'b0);
    step(10'h040, 1'b0);
    step(10'h040, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c <= DB; c++) begin
      step(10'h040, 1'b1);
      n_checks++;
      if (bus.out_valid !== (c == DB)) begin
        n_fail++;
        $display("FAIL async_reset_debounce edge=%0d got=%b exp=%b", c, bus.out_valid, c == DB);
      end
    end
    step(10'h040, 1'b1);
    exp_cnt = 2'd1;
    for (int z = 0; z < DB; z++) step(10'h000, 1'b1);
  endtask

  // Random press episodes: short bounces, a stable pattern, random ready
  // stalls with key noise, then noisy release ending in a quiet period.
  task automatic test_random();
    for (int e = 0; e < 30; e++) begin
      logic [9:0] prev;
      logic [9:0] k;
      logic [9:0] p;
      logic       r;
      int         nb;
      int         len;
      int         guard;
      prev = '0;
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) k = '0;
        else begin
          k = 10'($urandom_range(1, 1023));
          while (k == prev) k = 10'($urandom_range(1, 1023));
        end
        len = $urandom_range(1, DB);
        for (int c = 0; c < len; c++) begin
          step(k, 1'($urandom_range(0, 1)));
          n_checks++;
          if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_bounce ep=%0d key=%h got v=%b exp v=0", e, k, bus.out_valid);
          end
        end
        prev = k;
      end
      p = 10'($urandom_range(1, 1023));
      while (p == prev) p = 10'($urandom_range(1, 1023));
      for (int c = 0; c <= DB; c++) begin
        step(p, 1'($urandom_range(0, 1)));
        n_checks++;
        if (bus.out_valid !== (c == DB)) begin
          n_fail++;
          $display("FAIL rnd_valid ep=%0d key=%h edge=%0d got=%b exp=%b", e, p, c, bus.out_valid, c == DB);
        end
      end
      n_checks++;
      if (bus.out_code !== ref_code(p) || bus.out_multi !== ref_multi(p) || bus.press_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL rnd_code ep=%0d key=%h got c=%0d m=%b n=%0d exp c=%0d m=%b n=%0d", e, p,
                 bus.out_code, bus.out_multi, bus.press_cnt, ref_code(p), ref_multi(p), exp_cnt);
      end
      guard = 0;
      r = 1'b0;
      while (!r) begin
        guard++;
        r = (guard >= 8) ? 1'b1 : ($urandom_range(0, 2) == 0);
        step(10'($urandom_range(0, 1023)), r);
        if (r) exp_cnt++;
        n_checks++;
        if (bus.out_valid !== !r || bus.out_code !== ref_code(p) || bus.press_cnt !== exp_cnt) begin
          n_fail++;
          $display("FAIL rnd_present ep=%0d got v=%b c=%0d n=%0d exp v=%b c=%0d n=%0d", e,
                   bus.out_valid, bus.out_code, bus.press_cnt, !r, ref_code(p), exp_cnt);
        end
      end
      $display("rnd press %0d: key=%h code=%0d multi=%b cnt=%0d", e, p, ref_code(p), ref_multi(p), exp_cnt);
      len = $urandom_range(0, 5) + DB + $urandom_range(0, 2);
      for (int c = 0; c < len; c++) begin
        // noise first, then at least DB trailing zeros
        k = (c < len - DB - 2) ? 10'($urandom_range(0, 1023)) : 10'h000;
        step(k, 1'($urandom_range(0, 1)));
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_release ep=%0d key=%h got v=%b exp v=0", e, k, bus.out_valid);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.key = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_backpressure();
    test_wrap_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
